// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 mux with a registered valid/ready output stage.
// Optional multi-beat bursts per grant are enabled by defining MUX_ARB_BURST_EN.
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] ack,
  output logic       y,
  output logic       out_valid
);

  // Output handshake: a beat moves downstream in any cycle where out_valid && out_ready;
  // y and out_valid hold steady while out_valid && !out_ready.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, sel_n;
  logic [3:0] gnt_n, ack_n;
  logic       y_n, out_valid_n;
  logic       cap, last, pick_vld;
  logic [1:0] pick;

  if (MAX_BURST < 1 || (2 ** BURST_W) <= MAX_BURST) begin : g_bad_cfg
    $error("mux4_rr_arbiter: need MAX_BURST >= 1 and 2**BURST_W > MAX_BURST");
  end

  // Returns {found, index} of the first set request scanning from start upward, mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, start};
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {pick_vld, pick} = rr_pick(req, ptr);
  assign cap = (state == BUSY) && req[sel] && (!out_valid || out_ready);

`ifdef MUX_ARB_BURST_EN
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);
  logic [BURST_W-1:0] beat_cnt, beat_cnt_n;

  assign last = (beat_cnt == LAST_BEAT);

  always_comb begin
    beat_cnt_n = beat_cnt;
    if (state == IDLE && pick_vld) beat_cnt_n = '0;
    else if (cap)                  beat_cnt_n = beat_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else        beat_cnt <= beat_cnt_n;
  end
`else
  assign last = 1'b1;
`endif

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    sel_n       = sel;
    ptr_n       = ptr;
    ack_n       = 4'b0000;
    y_n         = y;
    out_valid_n = out_valid;

    if (cap) begin
      y_n         = din[sel];
      out_valid_n = 1'b1;
      ack_n       = gnt;
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = BUSY;
          gnt_n   = 4'b0001 << pick;
          sel_n   = pick;
        end else begin
          gnt_n   = 4'b0000;
        end
      end
      BUSY: begin
        // sel is kept after release; only the pointer moves past it.
        if (!req[sel] || (cap && last)) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          ptr_n   = sel + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      sel       <= 2'd0;
      ptr       <= 2'd0;
      ack       <= 4'b0000;
      y         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      ptr       <= ptr_n;
      ack       <= ack_n;
      y         <= y_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter; expectations are hand-computed per build
// (MUX_ARB_BURST_EN defined: 4-beat bursts, undefined: one beat per grant).
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] ack;
  logic       y;
  logic       out_valid;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       y;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(.MAX_BURST(4), .BURST_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .ack       (ack),
    .y         (y),
    .out_valid (out_valid)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Driver / checker tasks
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic [3:0] a, input logic yy, input logic ov);
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".sel"}, {2'b00, sel}, {2'b00, s});
    chk({tag, ".ack"}, ack, a);
    chk({tag, ".y"}, {3'b000, y}, {3'b000, yy});
    chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, ov});
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] d, input logic rdy,
                     input logic [3:0] g, input logic [1:0] s, input logic [3:0] a,
                     input logic yy, input logic ov);
    vec_t v;
    v.req = r; v.din = d; v.rdy = rdy;
    v.gnt = g; v.sel = s; v.ack = a; v.y = yy; v.ov = ov;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rdy);
    @(negedge clk);
    req = r; din = d; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; req = 4'b0000; din = 4'b0000; out_ready = 1'b0;

`ifdef MUX_ARB_BURST_EN
    add(4'b1111, 4'b1010, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      add(4'b1111, 4'b1010, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      add(4'b1111, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b1, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd1, 4'b0010, 1'b1, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b1);
    // Backpressure after two beats; the burst resumes with two beats left.
    for (int i = 0; i < 5; i++)
      add(4'b1111, 4'b1010, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd2, 4'b0100, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b1, 1'b1);
    // req[3] drops mid-burst together with out_ready: drain, release, pointer wraps to 0.
    add(4'b0111, 4'b1010, 1'b1, 4'b0000, 2'd3, 4'b0000, 1'b1, 1'b0);
    add(4'b1101, 4'b1011, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0);
    add(4'b1101, 4'b1011, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1, 1'b1);
`else
    add(4'b1111, 4'b1010, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd1, 4'b0010, 1'b1, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd2, 4'b0100, 1'b0, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b0);
    add(4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd3, 4'b1000, 1'b1, 1'b1);
    add(4'b1111, 4'b1010, 1'b1, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b1010, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b1, 1'b0);
    // Granted with zero beats, then dropped: pointer still moves to 3.
    add(4'b0100, 4'b1010, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0);
    add(4'b0000, 4'b1010, 1'b1, 4'b0000, 2'd2, 4'b0000, 1'b1, 1'b0);
    add(4'b1101, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b0000, 1'b1, 1'b0);
    add(4'b1101, 4'b0000, 1'b1, 4'b0000, 2'd3, 4'b1000, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b1);
    // Backpressure: beat pending, grant held for five stalled cycles.
    add(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      add(4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
    add(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b1, 1'b1);
    // req[sel] drops in the cycle out_ready returns: drain, no capture, release.
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b1);
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd1, 4'b0000, 1'b1, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 4'b0100, 1'b1, 1'b1);
`endif

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk_all("por", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].din, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].ack,
              vecs[i].y, vecs[i].ov);
    end

    // Asynchronous reset while a grant/beat is live clears everything without a clock edge.
    @(negedge clk);
    req = 4'b1110; out_ready = 1'b1;
    rst_n = 1'b0;
    #1 chk_all("rst_async", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_all("rst_hold", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("rst_ptr0", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
